// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit FIFO slice: state encoding,
// default depth and data width.
package uart_tx_fifo_pkg;

  localparam int unsigned DEPTH_DEFAULT = 16;
  localparam int unsigned AW_DEFAULT    = 4;
  localparam int unsigned DATA_W        = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// Byte storage for the transmit FIFO: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module sync_fifo_mem
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned AW    = AW_DEFAULT
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Combinational read so a pop captures the head byte on the same edge.
  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a uart_tx_8n1 transmitter: pops the head byte into
// txbyte, strobes senddata for one cycle and waits for txdone.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned AW    = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    wr_data,
  input  logic          wr_en,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic [7:0]    txbyte,
  output logic          senddata,
  input  logic          txdone,
  output logic          busy
);

  tx_state_e   state_q, state_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        overflow_q, overflow_d;
  logic [7:0]  txbyte_q, txbyte_d;
  logic        push;
  logic        pop;
  logic [7:0]  head_byte;

  // Pointers carry an extra wrap bit above the AW address bits.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;

  assign push = wr_en && !full;

  sync_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_q[AW-1:0]),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_q[AW-1:0]),
    .rd_data (head_byte)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (txdone) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = SEND;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    txbyte_d   = txbyte_q;
    overflow_d = overflow_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      txbyte_d = head_byte;
    end
    // full is the registered value, so a same-edge pop cannot rescue the write.
    if (wr_en && full) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      txbyte_q   <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      txbyte_q   <= txbyte_d;
    end
  end

  assign overflow = overflow_q;
  assign txbyte   = txbyte_q;
  assign senddata = (state_q == SEND);
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a vector table for the single-byte and
// "Hello" flows, then hand sequences for full/overflow, reset and wrap.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_en = 1'b0;
  logic       txdone_m = 1'b0;
  logic       txdone_a = 1'b0;
  logic       txdone;
  logic       full, empty, overflow, senddata, busy;
  logic [4:0] count;
  logic [7:0] txbyte;

  assign txdone = txdone_m | txdone_a;

  uart_tx_fifo #(
    .DEPTH (16),
    .AW    (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .txbyte   (txbyte),
    .senddata (senddata),
    .txdone   (txdone),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] mon_q[$];

  always @(negedge clk) begin
    if (senddata) mon_q.push_back(txbyte);
  end

  typedef struct {
    logic        we;
    logic [7:0]  d;
    logic        td;
    logic [17:0] exp;
  } vec_t;

  vec_t vecs[17];

  function automatic logic [17:0] exp_out(input logic [4:0] c, input logic e, input logic f,
                                          input logic o, input logic b, input logic s,
                                          input logic [7:0] tx);
    return {c, e, f, o, b, s, tx};
  endfunction

  function automatic logic [17:0] pack_out();
    return {count, empty, full, overflow, busy, senddata, txbyte};
  endfunction

  function automatic vec_t mkv(input logic we, input logic [7:0] d, input logic td,
                               input logic [17:0] e);
    vec_t v;
    v.we  = we;
    v.d   = d;
    v.td  = td;
    v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_cycle(input logic we, input logic [7:0] d, input logic td);
    @(negedge clk);
    wr_en    = we;
    wr_data  = d;
    txdone_m = td;
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    wr_en    = 1'b0;
    txdone_m = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    set_idle();
    rst = 1'b1;
    #2;
    check("reset_state", 32'(pack_out()), 32'(exp_out(5'd0, 1, 0, 0, 0, 0, 8'h00)));
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic fill(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b1, base + 8'(i), 1'b0);
  endtask

  // Acknowledges every frame while in WAIT until n strobes are seen and the FSM is idle.
  task automatic ack_until(input int n, input int budget);
    int cyc = 0;
    while (cyc < budget && !(mon_q.size() >= n && !busy)) begin
      @(negedge clk);
      txdone_a = busy && !senddata;
      cyc++;
    end
    txdone_a = 1'b0;
    check("ack_within_budget", 32'(cyc < budget), 32'd1);
  endtask

  task automatic check_q(input string name, input logic [7:0] exp[$]);
    check({name, "_len"}, 32'(mon_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      logic [31:0] got = 32'hFFFF_FFFF;
      if (i < mon_q.size()) got = 32'(mon_q[i]);
      check($sformatf("%s[%0d]", name, i), got, 32'(exp[i]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_q[$];

    vecs[0]  = mkv(1, 8'h48, 0, exp_out(5'd1, 0, 0, 0, 0, 0, 8'h00));
    vecs[1]  = mkv(0, 8'h00, 0, exp_out(5'd0, 1, 0, 0, 1, 1, 8'h48));
    vecs[2]  = mkv(0, 8'h00, 0, exp_out(5'd0, 1, 0, 0, 1, 0, 8'h48));
    vecs[3]  = mkv(0, 8'h00, 1, exp_out(5'd0, 1, 0, 0, 0, 0, 8'h48));
    vecs[4]  = mkv(0, 8'h00, 1, exp_out(5'd0, 1, 0, 0, 0, 0, 8'h48));
    vecs[5]  = mkv(1, 8'h48, 0, exp_out(5'd1, 0, 0, 0, 0, 0, 8'h48));
    vecs[6]  = mkv(1, 8'h65, 0, exp_out(5'd1, 0, 0, 0, 1, 1, 8'h48));
    vecs[7]  = mkv(1, 8'h6C, 0, exp_out(5'd2, 0, 0, 0, 1, 0, 8'h48));
    vecs[8]  = mkv(1, 8'h6C, 1, exp_out(5'd2, 0, 0, 0, 1, 1, 8'h65));
    vecs[9]  = mkv(1, 8'h6F, 1, exp_out(5'd3, 0, 0, 0, 1, 0, 8'h65));
    vecs[10] = mkv(0, 8'h00, 1, exp_out(5'd2, 0, 0, 0, 1, 1, 8'h6C));
    vecs[11] = mkv(0, 8'h00, 0, exp_out(5'd2, 0, 0, 0, 1, 0, 8'h6C));
    vecs[12] = mkv(0, 8'h00, 1, exp_out(5'd1, 0, 0, 0, 1, 1, 8'h6C));
    vecs[13] = mkv(0, 8'h00, 0, exp_out(5'd1, 0, 0, 0, 1, 0, 8'h6C));
    vecs[14] = mkv(0, 8'h00, 1, exp_out(5'd0, 1, 0, 0, 1, 1, 8'h6F));
    vecs[15] = mkv(0, 8'h00, 0, exp_out(5'd0, 1, 0, 0, 1, 0, 8'h6F));
    vecs[16] = mkv(0, 8'h00, 1, exp_out(5'd0, 1, 0, 0, 0, 0, 8'h6F));

    #1 rst = 1'b1;
    #2;
    check("reset_state", 32'(pack_out()), 32'(exp_out(5'd0, 1, 0, 0, 0, 0, 8'h00)));
    @(negedge clk);
    rst = 1'b0;

    // Single byte, then "Hello" with txdone after each send.
    mon_q.delete();
    for (int i = 0; i < 17; i++) begin
      drive_cycle(vecs[i].we, vecs[i].d, vecs[i].td);
      check($sformatf("vec%0d", i), 32'(pack_out()), 32'(vecs[i].exp));
    end
    set_idle();
    exp_q = '{8'h48, 8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    check_q("hello", exp_q);

    // Fill to full without acknowledgements, then one write too many.
    apply_reset();
    fill(8'h10, 17);
    check("fill17", 32'(pack_out()), 32'(exp_out(5'd16, 0, 1, 0, 1, 0, 8'h10)));
    drive_cycle(1'b1, 8'hEE, 1'b0);
    check("write18_ovf", 32'(pack_out()), 32'(exp_out(5'd16, 0, 1, 1, 1, 0, 8'h10)));
    set_idle();

    // Full FIFO: write and pop on the same edge drops the write.
    apply_reset();
    fill(8'h20, 17);
    check("refill17", 32'(pack_out()), 32'(exp_out(5'd16, 0, 1, 0, 1, 0, 8'h20)));
    mon_q.delete();
    drive_cycle(1'b1, 8'hDD, 1'b1);
    check("wr_pop_full", 32'(pack_out()), 32'(exp_out(5'd15, 0, 0, 1, 1, 1, 8'h21)));
    set_idle();
    ack_until(16, 200);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(8'h21 + 8'(i));
    check_q("drain", exp_q);
    check("drain_end", 32'(pack_out()), 32'(exp_out(5'd0, 1, 0, 1, 0, 0, 8'h30)));

    // Asynchronous reset while waiting for txdone with three bytes queued.
    apply_reset();
    fill(8'h30, 4);
    check("pre_rst_wait", 32'(pack_out()), 32'(exp_out(5'd3, 0, 0, 0, 1, 0, 8'h30)));
    set_idle();
    #2 rst = 1'b1;
    #1;
    check("async_rst", 32'(pack_out()), 32'(exp_out(5'd0, 1, 0, 0, 0, 0, 8'h00)));
    @(negedge clk);
    rst = 1'b0;
    mon_q.delete();
    drive_cycle(1'b0, 8'h00, 1'b1);
    set_idle();
    repeat (4) @(negedge clk);
    check("post_rst_strobes", 32'(mon_q.size()), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);

    // 40 bytes through a 16-deep FIFO: pointers wrap twice.
    apply_reset();
    mon_q.delete();
    exp_q.delete();
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          wr_en   = 1'b1;
          wr_data = 8'(i * 37 + 5);
          exp_q.push_back(8'(i * 37 + 5));
          @(negedge clk);
          wr_en = 1'b0;
        end
      end
      ack_until(40, 400);
    join
    check_q("wrap", exp_q);
    check("wrap_end", 32'(pack_out()), 32'(exp_out(5'd0, 1, 0, 0, 0, 0, 8'(39 * 37 + 5))));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
